// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle ALU: opcodes, flag bit positions and FSM states.
// Build option: define ALU_MOD_EN to include the MOD opcode and its divider datapath.
package alu_pkg;

  typedef enum logic [3:0] {
    OpAdd = 4'b0000,
    OpSub = 4'b0001,
    OpAnd = 4'b0010,
    OpOr  = 4'b0011,
    OpMov = 4'b0100,
    OpMul = 4'b0101,
    OpMod = 4'b0110
  } alu_op_e;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic [1:0] {
    StIdle,
    StIter,
    StDone
  } alu_state_e;

endpackage

// File: rtl/alu_iter_unit.sv
// Iterative datapath: shift-add multiplier and (with ALU_MOD_EN) restoring divider,
// one bit per step, sharing the 2N-bit {hi, lo} accumulator.
module alu_iter_unit
  import alu_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic         step_i,
`ifdef ALU_MOD_EN
  input  logic         mod_i,
`endif
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic         last_o,
  output logic [N-1:0] hi_o,
  output logic [N-1:0] lo_o
);

  localparam int unsigned CntW = $clog2(N) + 1;

  logic [N-1:0]    hi_q, hi_d;
  logic [N-1:0]    lo_q, lo_d;
  logic [N-1:0]    opd_q, opd_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [N:0]      mul_sum;
`ifdef ALU_MOD_EN
  logic            mod_q, mod_d;
  logic [N:0]      rem_sh;
  logic [N:0]      rem_diff;
`endif

  always_comb begin
    hi_d    = hi_q;
    lo_d    = lo_q;
    opd_d   = opd_q;
    cnt_d   = cnt_q;
    // Multiply: lo holds the unconsumed multiplier bits, product shifts in from the top.
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opd_q} : {(N + 1){1'b0}});
`ifdef ALU_MOD_EN
    mod_d    = mod_q;
    // Divide: hi is the partial remainder, lo shifts dividend out and quotient in.
    rem_sh   = {hi_q, lo_q[N-1]};
    rem_diff = rem_sh - {1'b0, opd_q};
`endif
    if (load_i) begin
      hi_d  = '0;
      cnt_d = '0;
`ifdef ALU_MOD_EN
      mod_d = mod_i;
      lo_d  = mod_i ? a_i : b_i;
      opd_d = mod_i ? b_i : a_i;
`else
      lo_d  = b_i;
      opd_d = a_i;
`endif
    end else if (step_i) begin
      cnt_d = cnt_q + 1'b1;
`ifdef ALU_MOD_EN
      if (mod_q) begin
        if (!rem_diff[N]) begin
          hi_d = rem_diff[N-1:0];
          lo_d = {lo_q[N-2:0], 1'b1};
        end else begin
          hi_d = rem_sh[N-1:0];
          lo_d = {lo_q[N-2:0], 1'b0};
        end
      end else begin
        hi_d = mul_sum[N:1];
        lo_d = {mul_sum[0], lo_q[N-1:1]};
      end
`else
      hi_d = mul_sum[N:1];
      lo_d = {mul_sum[0], lo_q[N-1:1]};
`endif
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hi_q  <= '0;
      lo_q  <= '0;
      opd_q <= '0;
      cnt_q <= '0;
`ifdef ALU_MOD_EN
      mod_q <= 1'b0;
`endif
    end else begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      opd_q <= opd_d;
      cnt_q <= cnt_d;
`ifdef ALU_MOD_EN
      mod_q <= mod_d;
`endif
    end
  end

  assign last_o = (cnt_q == CntW'(N - 1));
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU top: handshake FSM, single-cycle ops and registered result/NZCV flags.
// Build option: define ALU_MOD_EN to enable MOD (0110); otherwise 0110 is reserved.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [3:0]   opcode_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] result_o,
  output logic [3:0]   ALUFlags,
  output logic         busy_o,
  output logic         done_o
);

  alu_state_e   state_q, state_d;
  logic [3:0]   op_q;
  logic [N-1:0] a_q, b_q;
  logic         iter_op_q;
  logic [N-1:0] result_q;
  logic [3:0]   flags_q;
  logic         done_q;

  logic         accept;
  logic         iter_start;
  logic         step;
  logic         last;
  logic [N-1:0] iter_hi, iter_lo;
  logic [N:0]   add_sum, sub_diff;
  logic [N-1:0] res;
  logic         res_c, res_v;

  assign accept = start_i && (state_q == StIdle);
`ifdef ALU_MOD_EN
  assign iter_start = accept && ((opcode_i == OpMul) || ((opcode_i == OpMod) && (|b_i)));
`else
  assign iter_start = accept && (opcode_i == OpMul);
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = iter_start ? StIter : StDone;
      StIter:  if (last) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Busy covers the final DONE cycle of an iterative op, but never a single-cycle op.
  always_comb begin
    step   = (state_q == StIter);
    busy_o = (state_q == StIter) || ((state_q == StDone) && iter_op_q);
  end

  alu_iter_unit #(
    .N(N)
  ) u_iter (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (iter_start),
    .step_i (step),
`ifdef ALU_MOD_EN
    .mod_i  (opcode_i == OpMod),
`endif
    .a_i    (a_i),
    .b_i    (b_i),
    .last_o (last),
    .hi_o   (iter_hi),
    .lo_o   (iter_lo)
  );

  always_comb begin
    add_sum  = {1'b0, a_q} + {1'b0, b_q};
    sub_diff = {1'b0, a_q} - {1'b0, b_q};
    res      = '0;
    res_c    = 1'b0;
    res_v    = 1'b0;
    case (op_q)
      OpAdd: begin
        res   = add_sum[N-1:0];
        res_c = add_sum[N];
        res_v = (a_q[N-1] == b_q[N-1]) && (res[N-1] != a_q[N-1]);
      end
      OpSub: begin
        res   = sub_diff[N-1:0];
        res_c = ~sub_diff[N];
        res_v = (a_q[N-1] != b_q[N-1]) && (res[N-1] != a_q[N-1]);
      end
      OpAnd: res = a_q & b_q;
      OpOr:  res = a_q | b_q;
      OpMov: res = b_q;
      OpMul: begin
        res   = iter_lo;
        res_c = |iter_hi;
      end
`ifdef ALU_MOD_EN
      OpMod: begin
        if (b_q == '0) begin
          res   = a_q;
          res_v = 1'b1;
        end else begin
          res = iter_hi;
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      iter_op_q <= 1'b0;
      result_q  <= '0;
      flags_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      if (accept) begin
        op_q      <= opcode_i;
        a_q       <= a_i;
        b_q       <= b_i;
        iter_op_q <= iter_start;
      end
      done_q <= (state_q == StDone);
      if (state_q == StDone) begin
        result_q        <= res;
        flags_q[FLAG_N] <= res[N-1];
        flags_q[FLAG_Z] <= (res == '0);
        flags_q[FLAG_C] <= res_c;
        flags_q[FLAG_V] <= res_v;
      end
    end
  end

  assign result_o = result_q;
  assign ALUFlags = flags_q;
  assign done_o   = done_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed table-driven bench for alu_multicycle plus hand-written handshake/reset sequences.
module tb_alu_multicycle;

  localparam int unsigned N = 32;
  localparam int Timeout = 100;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [3:0]   opcode = '0;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic [N-1:0] result;
  logic [3:0]   flags;
  logic         busy;
  logic         done;

  alu_multicycle #(
    .N(N)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .start_i  (start),
    .opcode_i (opcode),
    .a_i      (a),
    .b_i      (b),
    .result_o (result),
    .ALUFlags (flags),
    .busy_o   (busy),
    .done_o   (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  flg;
    int          lat;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int   lat;
    logic seen_done;
    logic busy_bad;
    logic exp_busy;
    exp_busy = (v.lat > 1);
    @(negedge clk);
    opcode = v.op;
    a      = v.a;
    b      = v.b;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    a      = $urandom;
    b      = $urandom;
    opcode = 4'($urandom);
    check($sformatf("v%0d busy_after_accept", idx), {31'b0, busy}, {31'b0, exp_busy});
    lat       = 0;
    seen_done = 1'b0;
    busy_bad  = 1'b0;
    while (!seen_done && lat < Timeout) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) seen_done = 1'b1;
      else if (busy !== exp_busy) busy_bad = 1'b1;
    end
    check($sformatf("v%0d done_seen", idx), {31'b0, seen_done}, 32'd1);
    check($sformatf("v%0d latency", idx), lat, v.lat);
    check($sformatf("v%0d result", idx), result, v.res);
    check($sformatf("v%0d flags", idx), {28'b0, flags}, {28'b0, v.flg});
    check($sformatf("v%0d busy_at_done", idx), {31'b0, busy}, 32'd0);
    check($sformatf("v%0d busy_while_waiting", idx), {31'b0, busy_bad}, 32'd0);
    @(posedge clk);
    #1;
    check($sformatf("v%0d done_one_cycle", idx), {31'b0, done}, 32'd0);
  endtask

  initial begin
    int lat;
    int cnt;
    logic busy_seen;

    vecs.push_back('{4'b0000, 32'd1, 32'd10, 32'd11, 4'b0000, 1});
    vecs.push_back('{4'b0001, 32'd10, 32'd10, 32'd0, 4'b0110, 1});
    vecs.push_back('{4'b0001, 32'd1, 32'd10, 32'hFFFF_FFF7, 4'b1000, 1});
    vecs.push_back('{4'b0000, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 4'b1001, 1});
    vecs.push_back('{4'b0000, 32'hFFFF_FFFF, 32'd1, 32'd0, 4'b0110, 1});
    vecs.push_back('{4'b0001, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 4'b0011, 1});
    vecs.push_back('{4'b0010, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 4'b1000, 1});
    vecs.push_back('{4'b0011, 32'h0000_000F, 32'h0000_00F0, 32'h0000_00FF, 4'b0000, 1});
    vecs.push_back('{4'b0100, 32'd123, 32'd0, 32'd0, 4'b0100, 1});
    vecs.push_back('{4'b0101, 32'd7, 32'd6, 32'd42, 4'b0000, 33});
    vecs.push_back('{4'b0101, 32'h0001_0000, 32'h0001_0000, 32'd0, 4'b0110, 33});
    vecs.push_back('{4'b0101, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 4'b1010, 33});
`ifdef ALU_MOD_EN
    vecs.push_back('{4'b0110, 32'd100, 32'd7, 32'd2, 4'b0000, 33});
    vecs.push_back('{4'b0110, 32'd100, 32'd0, 32'd100, 4'b0001, 1});
    vecs.push_back('{4'b0110, 32'hFFFF_FFFF, 32'd10, 32'd5, 4'b0000, 33});
`else
    vecs.push_back('{4'b0110, 32'd100, 32'd7, 32'd0, 4'b0100, 1});
    vecs.push_back('{4'b0110, 32'd100, 32'd0, 32'd0, 4'b0100, 1});
`endif
    vecs.push_back('{4'b1111, 32'd5, 32'd9, 32'd0, 4'b0100, 1});
    vecs.push_back('{4'b0111, 32'd5, 32'd9, 32'd0, 4'b0100, 1});

    // Reset state
    #2;
    check("reset result", result, 32'd0);
    check("reset flags", {28'b0, flags}, 32'd0);
    check("reset busy", {31'b0, busy}, 32'd0);
    check("reset done", {31'b0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(vecs[i], i);
    end

    // A start pulsed while a MUL is busy must be dropped, not queued.
    @(negedge clk);
    opcode = 4'b0101;
    a      = 32'd7;
    b      = 32'd6;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = 0;
    while (!done && lat < Timeout) begin
      @(negedge clk);
      if (lat == 5) begin
        opcode = 4'b0000;
        a      = 32'd1;
        b      = 32'd1;
        start  = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    start = 1'b0;
    check("ignore latency", lat, 33);
    check("ignore result", result, 32'd42);
    check("ignore flags", {28'b0, flags}, 32'd0);
    cnt = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (done) cnt++;
    end
    check("ignore no_second_done", cnt, 0);

    // Reset at cycle 10 of a MUL aborts it immediately.
    @(negedge clk);
    opcode = 4'b0101;
    a      = 32'hFFFF_FFFF;
    b      = 32'd2;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort result", result, 32'd0);
    check("abort flags", {28'b0, flags}, 32'd0);
    check("abort busy", {31'b0, busy}, 32'd0);
    check("abort done", {31'b0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cnt       = 0;
    busy_seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) cnt++;
      if (busy) busy_seen = 1'b1;
    end
    check("abort no_done", cnt, 0);
    check("abort stays_idle", {31'b0, busy_seen}, 32'd0);

    // Start held high with ADD: one acceptance every two cycles.
    @(negedge clk);
    opcode = 4'b0000;
    a      = 32'd2;
    b      = 32'd3;
    start  = 1'b1;
    cnt       = 0;
    busy_seen = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk);
      #1;
      if (i == 7) start = 1'b0;
      if (done) cnt++;
      if (busy) busy_seen = 1'b1;
    end
    check("b2b done_count", cnt, 4);
    check("b2b never_busy", {31'b0, busy_seen}, 32'd0);
    check("b2b result", result, 32'd5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
